timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_pkg.sv | 10 +
 rtl/interval_counter.sv | 32 +++
 rtl/timer_ctrl.sv | 105 ++++++++++
 tb/tb_timer_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding and default width.
package timer_pkg;
  localparam int unsigned TIMER_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;
endpackage

// File: rtl/interval_counter.sv
// Elapsed-cycle counter for the interval timer; clear wins over enable.
module interval_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/timer_ctrl.sv
// Interval timer control: start handshake, one-shot/periodic sequencing,
// pause/stop handling and registered expire / cfg_err pulses.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             start_ready,
  input  logic [WIDTH-1:0] limit,
  input  logic             periodic,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire,
  output logic             cfg_err
);
  state_e           state_q;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             expire_q;
  logic             cfg_err_q;

  logic             limit_zero;
  logic             start_go;
  logic             run_go;
  logic             at_terminal;
  logic             cnt_clear;
  logic             cnt_en;

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign limit_zero  = (limit == '0);

  // stop overrides everything, so an accepted start or an advancing RUN cycle
  // both require stop low.
  assign start_go    = start_ready && start && !stop && !limit_zero;
  assign run_go      = (state_q == ST_RUN) && !pause && !stop;
  assign at_terminal = (count == (limit_q - WIDTH'(1)));

  assign cnt_clear = stop || start_go || (run_go && at_terminal);
  assign cnt_en    = run_go && !at_terminal;

  interval_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(cnt_clear),
    .en   (cnt_en),
    .count(count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      expire_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (limit_zero) begin
                cfg_err_q <= 1'b1;
              end else begin
                limit_q    <= limit;
                periodic_q <= periodic;
                state_q    <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSED;
            end else if (at_terminal) begin
              expire_q <= 1'b1;
              if (!periodic_q) begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_PAUSED: begin
            if (!pause) begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign expire  = expire_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: expected per-cycle outputs are queued as
// stimulus is applied and compared one entry per clock edge.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] cnt;
    logic         bsy;
    logic         exp;
    logic         cfg;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         start_ready;
  logic [W-1:0] limit;
  logic         periodic;
  logic         pause;
  logic         stop;
  logic [W-1:0] count;
  logic         busy;
  logic         expire;
  logic         cfg_err;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;
  int   max_cnt;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_ready(start_ready),
    .limit      (limit),
    .periodic   (periodic),
    .pause      (pause),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .expire     (expire),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input int c, input bit b, input bit e, input bit ce);
    exp_t x;
    x.cnt = c[W-1:0];
    x.bsy = b;
    x.exp = e;
    x.cfg = ce;
    sb_q.push_back(x);
  endtask

  // One clock edge; sample 1 time unit later and check against the oldest entry.
  task automatic tick(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (int'(count) > max_cnt) max_cnt = int'(count);
    $display("t=%0t %s cnt=%0d busy=%0b expire=%0b cfg_err=%0b", $time, tag, count, busy, expire, cfg_err);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_count"},   32'(count),   32'(x.cnt));
      chk({tag, "_busy"},    32'(busy),    32'(x.bsy));
      chk({tag, "_expire"},  32'(expire),  32'(x.exp));
      chk({tag, "_cfg_err"}, 32'(cfg_err), 32'(x.cfg));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0; max_cnt = 0;
    rst_n = 1'b0; start = 1'b1; limit = 8'd4; periodic = 1'b0; pause = 1'b0; stop = 1'b0;

    // Reset held for 3 edges with start high, then one-shot limit 4 from release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_expire", 32'(expire), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    push(0, 1, 0, 0);
    tick("oneshot_accept");
    start = 1'b0;
    push(1, 1, 0, 0); push(2, 1, 0, 0); push(3, 1, 0, 0);
    push(0, 0, 1, 0); push(0, 0, 0, 0);
    repeat (5) tick("oneshot");

    // Periodic limit 3, start held high while busy with a different limit.
    limit = 8'd3; periodic = 1'b1; start = 1'b1;
    push(0, 1, 0, 0);
    tick("per_accept");
    limit = 8'd7; periodic = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push(1, 1, 0, 0); push(2, 1, 0, 0); push(0, 1, 1, 0);
    end
    repeat (12) tick("periodic");
    stop = 1'b1;
    push(0, 0, 0, 0);
    tick("per_stop");
    chk("idle_start_ready", 32'(start_ready), 32'd1);
    push(0, 0, 0, 0);
    tick("stop_vs_start");
    stop = 1'b0; start = 1'b0;

    // Pause for 3 edges at count 2 of a one-shot limit 5.
    limit = 8'd5; periodic = 1'b0; start = 1'b1;
    push(0, 1, 0, 0);
    tick("pause_accept");
    start = 1'b0;
    push(1, 1, 0, 0); push(2, 1, 0, 0);
    repeat (2) tick("pause_run");
    pause = 1'b1;
    push(2, 1, 0, 0); push(2, 1, 0, 0); push(2, 1, 0, 0);
    repeat (3) tick("paused");
    pause = 1'b0;
    push(2, 1, 0, 0); push(3, 1, 0, 0); push(4, 1, 0, 0);
    push(0, 0, 1, 0); push(0, 0, 0, 0);
    repeat (5) tick("pause_resume");

    // Pause coincident with the terminal count suppresses expire until release.
    start = 1'b1;
    push(0, 1, 0, 0);
    tick("pterm_accept");
    start = 1'b0;
    push(1, 1, 0, 0); push(2, 1, 0, 0); push(3, 1, 0, 0); push(4, 1, 0, 0);
    repeat (4) tick("pterm_run");
    pause = 1'b1;
    push(4, 1, 0, 0);
    tick("pterm_hold");
    pause = 1'b0;
    push(4, 1, 0, 0); push(0, 0, 1, 0); push(0, 0, 0, 0);
    repeat (3) tick("pterm_release");

    // Abort at count 3 of limit 10.
    limit = 8'd10; start = 1'b1;
    push(0, 1, 0, 0);
    tick("abort_accept");
    start = 1'b0;
    push(1, 1, 0, 0); push(2, 1, 0, 0); push(3, 1, 0, 0);
    repeat (3) tick("abort_run");
    stop = 1'b1;
    push(0, 0, 0, 0);
    tick("abort_stop");
    stop = 1'b0;
    push(0, 0, 0, 0);
    tick("abort_after");

    // Rejected start with limit 0.
    limit = 8'd0; start = 1'b1;
    push(0, 0, 0, 1);
    tick("cfg_err_pulse");
    start = 1'b0;
    push(0, 0, 0, 0);
    tick("cfg_err_clear");

    // Full-range one-shot, limit 255.
    limit = 8'd255; start = 1'b1;
    push(0, 1, 0, 0);
    tick("max_accept");
    start = 1'b0;
    max_cnt = 0;
    for (int i = 1; i <= 254; i++) push(i, 1, 0, 0);
    repeat (254) tick("max_run");
    push(0, 0, 1, 0);
    tick("max_expire");
    chk("max_count_seen", 32'(max_cnt), 32'd254);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    push(0, 1, 0, 0);
    tick("arst_accept");
    start = 1'b0;
    for (int i = 1; i <= 10; i++) push(i, 1, 0, 0);
    repeat (10) tick("arst_run");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) push(0, 0, 0, 0);
    repeat (4) tick("arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
